// File: rtl/segrw_pkg.sv
// Shared definitions for the segment read/write arbiter slice: requester IDs,
// op-type encodings and the default geometry of the segment and tag queue.
package segrw_pkg;

    localparam int AW_DEFAULT         = 4;
    localparam int DW_DEFAULT         = 8;
    localparam int TAGQ_DEPTH_DEFAULT = 4;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // The requester that gets priority after the given one has been served.
    function automatic req_id_t other_req(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/segrw_tagq.sv
// In-order tag queue: remembers which requester issued each outstanding read
// so the returning words can be steered back. 1-bit wide, DEPTH deep.
module segrw_tagq
    import segrw_pkg::*;
#(
    parameter int DEPTH = TAGQ_DEPTH_DEFAULT,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  req_id_t       din,
    output req_id_t       dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Status flags come straight from the registered count; a push while full
    // is refused even if a pop happens in the same cycle.
    always_comb begin
        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        dout    = mem[rd_ptr];
    end

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/segrw_arb2.sv
// Two-requester round-robin arbiter in front of a single segment read/write
// port. Ops pass through combinationally; read return data is steered back to
// the issuing requester using an in-order tag queue.
module segrw_arb2
    import segrw_pkg::*;
#(
    parameter int AW         = AW_DEFAULT,
    parameter int DW         = DW_DEFAULT,
    parameter int TAGQ_DEPTH = TAGQ_DEPTH_DEFAULT,
    localparam int CW = $clog2(TAGQ_DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,

    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_dataW,
    input  logic          r0_write,
    input  logic          r0_valid,
    output logic          r0_ready,
    output logic [DW-1:0] r0_dataR,
    output logic          r0_rvalid,
    input  logic          r0_rready,

    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_dataW,
    input  logic          r1_write,
    input  logic          r1_valid,
    output logic          r1_ready,
    output logic [DW-1:0] r1_dataR,
    output logic          r1_rvalid,
    input  logic          r1_rready,

    output logic [AW-1:0] seg_addr,
    output logic [DW-1:0] seg_dataW,
    output logic          seg_write,
    output logic          seg_valid,
    input  logic          seg_ready,
    input  logic [DW-1:0] seg_dataR,
    input  logic          seg_rvalid,
    output logic          seg_rready,

    output logic [CW-1:0] outstanding,
    output logic          err
);

    req_id_t       rr_ptr;
    req_id_t       grant;
    req_id_t       head_id;
    logic          elig0;
    logic          elig1;
    logic          accept;
    logic          tagq_push;
    logic          tagq_pop;
    logic          tagq_empty;
    logic          tagq_full;
    logic [CW-1:0] tagq_count;

    // Eligibility and grant: a read may only issue if the tag queue has room,
    // writes are never blocked by the queue. Ties go to rr_ptr.
    always_comb begin
        elig0 = r0_valid & ((r0_write == OP_WRITE) | ~tagq_full);
        elig1 = r1_valid & ((r1_write == OP_WRITE) | ~tagq_full);
        if (elig0 & elig1) begin
            grant = rr_ptr;
        end else if (elig1) begin
            grant = REQ1;
        end else begin
            grant = REQ0;
        end
    end

    // Issue path: mux the granted op onto the segment and hand back ready.
    always_comb begin
        seg_valid = elig0 | elig1;
        if (grant == REQ1) begin
            seg_addr  = r1_addr;
            seg_dataW = r1_dataW;
            seg_write = r1_write;
        end else begin
            seg_addr  = r0_addr;
            seg_dataW = r0_dataW;
            seg_write = r0_write;
        end
        r0_ready  = (grant == REQ0) & elig0 & seg_ready;
        r1_ready  = (grant == REQ1) & elig1 & seg_ready;
        accept    = seg_valid & seg_ready;
        tagq_push = accept & (seg_write == OP_READ);
    end

    // Return path: the queue head names the owner of the next returning word.
    // With an empty queue any stray word is swallowed so the segment never stalls.
    always_comb begin
        r0_rvalid  = seg_rvalid & ~tagq_empty & (head_id == REQ0);
        r1_rvalid  = seg_rvalid & ~tagq_empty & (head_id == REQ1);
        r0_dataR   = (~tagq_empty & (head_id == REQ0)) ? seg_dataR : '0;
        r1_dataR   = (~tagq_empty & (head_id == REQ1)) ? seg_dataR : '0;
        seg_rready = tagq_empty | ((head_id == REQ1) ? r1_rready : r0_rready);
        tagq_pop   = seg_rvalid & seg_rready & ~tagq_empty;
    end

    // Round-robin pointer: after an accept the other requester wins a tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= REQ0;
        end else if (accept) begin
            rr_ptr <= other_req(grant);
        end
    end

    // Sticky protocol error: return data arrived with nothing outstanding.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (seg_rvalid & tagq_empty) begin
            err <= 1'b1;
        end
    end

    assign outstanding = tagq_count;

    segrw_tagq #(
        .DEPTH (TAGQ_DEPTH)
    ) u_tagq (
        .clock (clock),
        .reset (reset),
        .push  (tagq_push),
        .pop   (tagq_pop),
        .din   (grant),
        .dout  (head_id),
        .empty (tagq_empty),
        .full  (tagq_full),
        .count (tagq_count)
    );

endmodule

// File: tb/tb_segrw_arb2.sv
// Self-checking bench for segrw_arb2. The bench plays the segment itself and
// predicts every cycle's outputs from a queue-based model of the arbiter rules.
module tb_segrw_arb2;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clock;
    logic          reset;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_dataW, r1_dataW;
    logic          r0_write, r1_write, r0_valid, r1_valid;
    logic          r0_ready, r1_ready;
    logic [DW-1:0] r0_dataR, r1_dataR;
    logic          r0_rvalid, r1_rvalid, r0_rready, r1_rready;
    logic [AW-1:0] seg_addr;
    logic [DW-1:0] seg_dataW;
    logic          seg_write, seg_valid, seg_ready;
    logic [DW-1:0] seg_dataR;
    logic          seg_rvalid, seg_rready;
    logic [2:0]    outstanding;
    logic          err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          pendq[$];
    logic [DW-1:0] segMem[16];
    logic          modelRr;
    logic          modelErr;

    segrw_arb2 #(.AW(AW), .DW(DW), .TAGQ_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .r0_addr(r0_addr), .r0_dataW(r0_dataW), .r0_write(r0_write), .r0_valid(r0_valid),
        .r0_ready(r0_ready), .r0_dataR(r0_dataR), .r0_rvalid(r0_rvalid), .r0_rready(r0_rready),
        .r1_addr(r1_addr), .r1_dataW(r1_dataW), .r1_write(r1_write), .r1_valid(r1_valid),
        .r1_ready(r1_ready), .r1_dataR(r1_dataR), .r1_rvalid(r1_rvalid), .r1_rready(r1_rready),
        .seg_addr(seg_addr), .seg_dataW(seg_dataW), .seg_write(seg_write), .seg_valid(seg_valid),
        .seg_ready(seg_ready), .seg_dataR(seg_dataR), .seg_rvalid(seg_rvalid), .seg_rready(seg_rready),
        .outstanding(outstanding), .err(err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count a comparison and report it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    // Drive one cycle of stimulus, compare against the model, then advance the model.
    task automatic applyStimulus(
        input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0, input logic rr0,
        input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic rr1,
        input logic sready, input logic srvalid);
        logic full, e0, e1, g, qEmpty, head, expSrr, accept;
        logic [AW-1:0] ga;
        @(negedge clock);
        r0_valid = v0; r0_write = w0; r0_addr = a0; r0_dataW = d0; r0_rready = rr0;
        r1_valid = v1; r1_write = w1; r1_addr = a1; r1_dataW = d1; r1_rready = rr1;
        seg_ready  = sready;
        seg_rvalid = srvalid;
        seg_dataR  = (pendq.size() > 0) ? pendq[0].data : DW'($urandom);
        #1;
        full   = (pendq.size() == DEPTH);
        e0     = v0 && (w0 || !full);
        e1     = v1 && (w1 || !full);
        g      = (e0 && e1) ? modelRr : (e1 ? 1'b1 : 1'b0);
        accept = (e0 || e1) && sready;
        qEmpty = (pendq.size() == 0);
        head   = qEmpty ? 1'b0 : pendq[0].id;
        expSrr = qEmpty ? 1'b1 : (head ? rr1 : rr0);

        checkOutput("seg_valid", 32'(seg_valid), 32'(e0 || e1));
        checkOutput("r0_ready", 32'(r0_ready), 32'(e0 && !g && sready));
        checkOutput("r1_ready", 32'(r1_ready), 32'(e1 && g && sready));
        if (e0 || e1) begin
            checkOutput("seg_addr", 32'(seg_addr), g ? 32'(a1) : 32'(a0));
            checkOutput("seg_write", 32'(seg_write), g ? 32'(w1) : 32'(w0));
            if (g ? w1 : w0)
                checkOutput("seg_dataW", 32'(seg_dataW), g ? 32'(d1) : 32'(d0));
        end
        checkOutput("r0_rvalid", 32'(r0_rvalid), 32'(srvalid && !qEmpty && !head));
        checkOutput("r1_rvalid", 32'(r1_rvalid), 32'(srvalid && !qEmpty && head));
        if (srvalid && !qEmpty) begin
            if (head) checkOutput("r1_dataR", 32'(r1_dataR), 32'(pendq[0].data));
            else      checkOutput("r0_dataR", 32'(r0_dataR), 32'(pendq[0].data));
        end
        checkOutput("seg_rready", 32'(seg_rready), 32'(expSrr));
        checkOutput("outstanding", 32'(outstanding), 32'(pendq.size()));
        checkOutput("err", 32'(err), 32'(modelErr));

        if (srvalid && qEmpty) modelErr = 1'b1;
        if (srvalid && !qEmpty && expSrr) void'(pendq.pop_front());
        if (accept) begin
            ga = g ? a1 : a0;
            modelRr = ~g;
            if (g ? w1 : w0) segMem[ga] = g ? d1 : d0;
            else             pendq.push_back('{id: g, data: segMem[ga]});
        end
    endtask

    // Assert reset for a few cycles, check the reset state, clear the model.
    task automatic resetDut();
        @(negedge clock);
        reset = 1'b0;
        r0_valid = 1'b0; r1_valid = 1'b0; seg_rvalid = 1'b0;
        #1;
        checkOutput("rst_outstanding", 32'(outstanding), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_r0_rvalid", 32'(r0_rvalid), 32'd0);
        checkOutput("rst_r1_rvalid", 32'(r1_rvalid), 32'd0);
        checkOutput("rst_seg_valid", 32'(seg_valid), 32'd0);
        pendq.delete();
        modelRr  = 1'b0;
        modelErr = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Return every outstanding read with both requesters ready; bounded.
    task automatic drainQueue();
        for (int i = 0; i < 3 * DEPTH && pendq.size() > 0; i++)
            applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1);
        checkOutput("drain_bound", 32'(pendq.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        r0_valid = 0; r0_write = 0; r0_addr = 0; r0_dataW = 0; r0_rready = 0;
        r1_valid = 0; r1_write = 0; r1_addr = 0; r1_dataW = 0; r1_rready = 0;
        seg_ready = 0; seg_rvalid = 0; seg_dataR = 0;
        for (int i = 0; i < 16; i++) segMem[i] = DW'($urandom);
        modelRr = 1'b0; modelErr = 1'b0;
        resetDut();

        $display("[TB] contention: both read, addr 3 vs 5");
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 0, 4'd3, 0, 1, 1, 0, 4'd5, 0, 1, 1, (pendq.size() > 0));
        drainQueue();

        $display("[TB] steering: r0 writes A5 to 2, r1 reads it back");
        applyStimulus(1, 1, 4'd2, 8'hA5, 1, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 4'd2, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1);

        $display("[TB] queue full with returns held off");
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1, 0, 4'(i), 0, 1, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 4'd7, 0, 1, 1, 1, 4'd9, 8'h3C, 1, 1, 0);
        applyStimulus(1, 0, 4'd7, 0, 1, 0, 0, 0, 0, 1, 1, 1);
        applyStimulus(1, 0, 4'd7, 0, 1, 0, 0, 0, 0, 1, 1, 0);
        drainQueue();

        $display("[TB] head back-pressure");
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 4'd4, 0, 0, 1, 0);
        applyStimulus(1, 0, 4'd6, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2000; i++) begin
            logic sv;
            sv = (pendq.size() > 0) && ($urandom_range(0, 3) < ((i / 250) % 2 == 0 ? 3 : 1));
            applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, AW'($urandom), DW'($urandom),
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, AW'($urandom), DW'($urandom),
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 4) != 0, sv);
        end
        drainQueue();

        $display("[TB] reset with reads outstanding");
        applyStimulus(1, 0, 4'd1, 0, 1, 1, 0, 4'd2, 0, 1, 1, 0);
        applyStimulus(1, 0, 4'd1, 0, 1, 1, 0, 4'd2, 0, 1, 1, 0);
        resetDut();
        applyStimulus(1, 0, 4'd8, 0, 1, 1, 0, 4'd9, 0, 1, 1, 0);
        drainQueue();

        $display("[TB] protocol error: return with empty queue");
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0);
        resetDut();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
